// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared types and widths for the cache-to-memory arbiter.
//               arb_state_t - arbiter FSM state encoding.
//               c_ADR_W / c_DAT_W / c_SEL_W - Wishbone field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    localparam int c_ADR_W = 12;
    localparam int c_DAT_W = 128;
    localparam int c_SEL_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/arbiter_control.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_control
// Description : Arbitration FSM and last-granted flag for cache_arbiter.
//               Ports:
//                 clk, rst_n          - clock, async active-low reset
//                 i_req_i / i_req_d   - icache / dcache request (STB && CYC)
//                 i_cyc_i / i_cyc_d   - CYC of each port (abort detection)
//                 i_mem_ack           - memory acknowledge
//                 o_state             - current FSM state (registered)
//                 o_load              - IDLE->GRANT transition this cycle
//                 o_load_d            - winner of that transition is dcache
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_control
    import lc3b_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_cyc_i,
    input  logic       i_cyc_d,
    input  logic       i_mem_ack,
    output arb_state_t o_state,
    output logic       o_load,
    output logic       o_load_d
);

    arb_state_t r_state;
    // 1 = icache was granted last, 0 = dcache was granted last.
    logic       r_last_i;
    logic       w_win_d;

    // dcache wins when it is alone, when priority is fixed, or when icache
    // had the previous grant.
    assign w_win_d  = i_req_d && (!i_req_i || !RR_EN || r_last_i);
    assign o_load   = (r_state == IDLE) && (i_req_i || i_req_d);
    assign o_load_d = w_win_d;
    assign o_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_i <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A mem ACK seen here is spurious and simply ignored.
                    if (i_req_i || i_req_d) begin
                        r_state <= w_win_d ? GRANT_D : GRANT_I;
                    end
                end
                GRANT_I: begin
                    // Completion or abort both end the grant.
                    if (i_mem_ack || !i_cyc_i) begin
                        r_state  <= IDLE;
                        r_last_i <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (i_mem_ack || !i_cyc_d) begin
                        r_state  <= IDLE;
                        r_last_i <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : arbiter_control
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Arbitrates icache and dcache Wishbone miss ports onto a single
//               Wishbone memory master port. The winner's request fields are
//               latched at grant time; memory read data and ACK are routed
//               back combinationally.
//               Ports:
//                 clk, rst_n        - clock, async active-low reset
//                 i/o_icache_*      - icache slave port (ADR/DAT/SEL/WE/STB/CYC/ACK)
//                 i/o_dcache_*      - dcache slave port
//                 o/i_mem_*         - memory master port
//                 busy              - a grant is outstanding
//               Parameter RR_EN: 1 = round-robin, 0 = dcache priority.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import lc3b_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    // icache slave port
    input  logic [c_ADR_W-1:0] i_icache_adr,
    input  logic [c_DAT_W-1:0] i_icache_dat_m,
    input  logic [c_SEL_W-1:0] i_icache_sel,
    input  logic               i_icache_we,
    input  logic               i_icache_stb,
    input  logic               i_icache_cyc,
    output logic [c_DAT_W-1:0] o_icache_dat_s,
    output logic               o_icache_ack,
    // dcache slave port
    input  logic [c_ADR_W-1:0] i_dcache_adr,
    input  logic [c_DAT_W-1:0] i_dcache_dat_m,
    input  logic [c_SEL_W-1:0] i_dcache_sel,
    input  logic               i_dcache_we,
    input  logic               i_dcache_stb,
    input  logic               i_dcache_cyc,
    output logic [c_DAT_W-1:0] o_dcache_dat_s,
    output logic               o_dcache_ack,
    // memory master port
    output logic [c_ADR_W-1:0] o_mem_adr,
    output logic [c_DAT_W-1:0] o_mem_dat_m,
    output logic [c_SEL_W-1:0] o_mem_sel,
    output logic               o_mem_we,
    output logic               o_mem_stb,
    output logic               o_mem_cyc,
    input  logic [c_DAT_W-1:0] i_mem_dat_s,
    input  logic               i_mem_ack,
    // status
    output logic               busy
);

    arb_state_t         w_state;
    logic               w_req_i;
    logic               w_req_d;
    logic               w_load;
    logic               w_load_d;
    logic               w_active;

    logic [c_ADR_W-1:0] r_adr;
    logic [c_DAT_W-1:0] r_dat_m;
    logic [c_SEL_W-1:0] r_sel;
    logic               r_we;

    assign w_req_i = i_icache_stb && i_icache_cyc;
    assign w_req_d = i_dcache_stb && i_dcache_cyc;

    arbiter_control #(
        .RR_EN (RR_EN)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_i   (w_req_i),
        .i_req_d   (w_req_d),
        .i_cyc_i   (i_icache_cyc),
        .i_cyc_d   (i_dcache_cyc),
        .i_mem_ack (i_mem_ack),
        .o_state   (w_state),
        .o_load    (w_load),
        .o_load_d  (w_load_d)
    );

    // Request latch: memory sees a stable copy of the winner's request even
    // if the requester changes its outputs during the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr   <= '0;
            r_dat_m <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
        end else if (w_load) begin
            if (w_load_d) begin
                r_adr   <= i_dcache_adr;
                r_dat_m <= i_dcache_dat_m;
                r_sel   <= i_dcache_sel;
                r_we    <= i_dcache_we;
            end else begin
                r_adr   <= i_icache_adr;
                r_dat_m <= i_icache_dat_m;
                r_sel   <= i_icache_sel;
                r_we    <= i_icache_we;
            end
        end
    end

    // Strobe follows the granted requester so a dropped STB/CYC is seen by
    // memory in the same cycle.
    assign w_active = ((w_state == GRANT_I) && w_req_i) ||
                      ((w_state == GRANT_D) && w_req_d);

    assign o_mem_adr   = r_adr;
    assign o_mem_dat_m = r_dat_m;
    assign o_mem_sel   = r_sel;
    assign o_mem_we    = r_we;
    assign o_mem_stb   = w_active;
    assign o_mem_cyc   = w_active;

    assign o_icache_dat_s = i_mem_dat_s;
    assign o_dcache_dat_s = i_mem_dat_s;
    assign o_icache_ack   = (w_state == GRANT_I) && i_mem_ack;
    assign o_dcache_ack   = (w_state == GRANT_D) && i_mem_ack;

    assign busy = (w_state != IDLE);

endmodule : cache_arbiter
`default_nettype wire
